// File: rtl/alu_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : alu_arbiter
// Brief    : Shares one combinational ALU between two valid/ready requesters.
//            Define ALU_ARB_ROUND_ROBIN_EN for round-robin, else fixed priority.
// Revision : 1.0 - initial release
// ============================================================================
module alu_arbiter #(
    parameter int WIDTH  = 16,
    parameter int CTRL_W = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req0_valid,
    input  logic              req1_valid,
    output logic              req0_ready,
    output logic              req1_ready,
    input  logic [WIDTH-1:0]  req0_src1,
    input  logic [WIDTH-1:0]  req0_src2,
    input  logic [WIDTH-1:0]  req1_src1,
    input  logic [WIDTH-1:0]  req1_src2,
    input  logic [CTRL_W-1:0] req0_op,
    input  logic [CTRL_W-1:0] req1_op,
    output logic              rsp0_valid,
    output logic              rsp1_valid,
    input  logic              rsp0_ready,
    input  logic              rsp1_ready,
    output logic [WIDTH:0]    rsp_result,
    output logic              rsp_zero,
    output logic              rsp_err,
    output logic [WIDTH-1:0]  alu_src1,
    output logic [WIDTH-1:0]  alu_src2,
    output logic [CTRL_W-1:0] alu_ctrl,
    input  logic [WIDTH:0]    alu_result,
    input  logic              alu_zero
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_EXEC = 2'd1;
    localparam logic [1:0] S_RESP = 2'd2;

    logic [1:0]        r_state;
    logic [1:0]        w_next_state;
    logic              r_owner;
    logic [WIDTH-1:0]  r_alu_src1;
    logic [WIDTH-1:0]  r_alu_src2;
    logic [CTRL_W-1:0] r_alu_ctrl;
    logic [WIDTH:0]    r_rsp_result;
    logic              r_rsp_zero;
    logic              r_rsp_err;
    logic              w_grant_any;
    logic              w_grant_sel;
    logic              w_op_legal;
    logic              w_rsp_take;

    assign w_grant_any = (r_state == S_IDLE) && (req0_valid || req1_valid);
    assign w_rsp_take  = r_owner ? rsp1_ready : rsp0_ready;

`ifdef ALU_ARB_ROUND_ROBIN_EN
    // r_last holds the most recent winner; on contention the other side wins.
    logic r_last;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_last <= 1'b1;
        end else if (w_grant_any) begin
            r_last <= w_grant_sel;
        end
    end

    assign w_grant_sel = req1_valid && (!req0_valid || !r_last);
`else
    assign w_grant_sel = req1_valid && !req0_valid;
`endif

    always_comb begin
        case (r_alu_ctrl)
            CTRL_W'(0), CTRL_W'(1), CTRL_W'(2), CTRL_W'(6),
            CTRL_W'(7), CTRL_W'(8), CTRL_W'(12): w_op_legal = 1'b1;
            default:                             w_op_legal = 1'b0;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            S_IDLE:  if (req0_valid || req1_valid) w_next_state = S_EXEC;
            S_EXEC:  w_next_state = S_RESP;
            S_RESP:  if (w_rsp_take) w_next_state = S_IDLE;
            default: w_next_state = S_IDLE;
        endcase
    end

    // Ready is gated by rst so every output reads 0 while reset is held.
    always_comb begin
        req0_ready = 1'b0;
        req1_ready = 1'b0;
        rsp0_valid = 1'b0;
        rsp1_valid = 1'b0;
        if (!rst) begin
            case (r_state)
                S_IDLE: begin
                    req0_ready = req0_valid && !w_grant_sel;
                    req1_ready = w_grant_sel;
                end
                S_RESP: begin
                    rsp0_valid = !r_owner;
                    rsp1_valid = r_owner;
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_owner      <= 1'b0;
            r_alu_src1   <= '0;
            r_alu_src2   <= '0;
            r_alu_ctrl   <= '0;
            r_rsp_result <= '0;
            r_rsp_zero   <= 1'b0;
            r_rsp_err    <= 1'b0;
        end else begin
            if (w_grant_any) begin
                r_owner    <= w_grant_sel;
                r_alu_src1 <= w_grant_sel ? req1_src1 : req0_src1;
                r_alu_src2 <= w_grant_sel ? req1_src2 : req0_src2;
                r_alu_ctrl <= w_grant_sel ? req1_op   : req0_op;
            end
            if (r_state == S_EXEC) begin
                r_rsp_err    <= !w_op_legal;
                r_rsp_result <= w_op_legal ? alu_result : '0;
                r_rsp_zero   <= w_op_legal && alu_zero;
            end
        end
    end

    assign alu_src1   = r_alu_src1;
    assign alu_src2   = r_alu_src2;
    assign alu_ctrl   = r_alu_ctrl;
    assign rsp_result = r_rsp_result;
    assign rsp_zero   = r_rsp_zero;
    assign rsp_err    = r_rsp_err;

endmodule
`default_nettype wire

// File: tb/tb_alu_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_alu_arbiter
// Brief    : Transaction-level model bench for alu_arbiter with an ALU stub.
// Revision : 1.0 - initial release
// ============================================================================
module tb_alu_arbiter;

    localparam int WIDTH  = 16;
    localparam int CTRL_W = 4;

    logic              clk = 1'b0;
    logic              rst;
    logic              req0_valid, req1_valid, req0_ready, req1_ready;
    logic [WIDTH-1:0]  req0_src1, req0_src2, req1_src1, req1_src2;
    logic [CTRL_W-1:0] req0_op, req1_op;
    logic              rsp0_valid, rsp1_valid, rsp0_ready, rsp1_ready;
    logic [WIDTH:0]    rsp_result;
    logic              rsp_zero, rsp_err;
    logic [WIDTH-1:0]  alu_src1, alu_src2;
    logic [CTRL_W-1:0] alu_ctrl;
    logic [WIDTH:0]    alu_result;
    logic              alu_zero;

    always #5 clk = ~clk;

    alu_arbiter #(.WIDTH(WIDTH), .CTRL_W(CTRL_W)) dut (
        .clk(clk), .rst(rst),
        .req0_valid(req0_valid), .req1_valid(req1_valid),
        .req0_ready(req0_ready), .req1_ready(req1_ready),
        .req0_src1(req0_src1), .req0_src2(req0_src2),
        .req1_src1(req1_src1), .req1_src2(req1_src2),
        .req0_op(req0_op), .req1_op(req1_op),
        .rsp0_valid(rsp0_valid), .rsp1_valid(rsp1_valid),
        .rsp0_ready(rsp0_ready), .rsp1_ready(rsp1_ready),
        .rsp_result(rsp_result), .rsp_zero(rsp_zero), .rsp_err(rsp_err),
        .alu_src1(alu_src1), .alu_src2(alu_src2), .alu_ctrl(alu_ctrl),
        .alu_result(alu_result), .alu_zero(alu_zero)
    );

    function automatic logic is_legal(input logic [3:0] op);
        return op inside {4'd0, 4'd1, 4'd2, 4'd6, 4'd7, 4'd8, 4'd12};
    endfunction

    // ALU stub; illegal codes return junk with Zero set so forcing is visible.
    function automatic logic [WIDTH:0] alu_fn(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                                               input logic [3:0] op);
        case (op)
            4'd0:    return {1'b0, a & b};
            4'd1:    return {1'b0, a | b};
            4'd2:    return {1'b0, a} + {1'b0, b};
            4'd6:    return {1'b0, a} - {1'b0, b};
            4'd7:    return {16'd0, ($signed(a) < $signed(b))};
            4'd8:    return {1'b0, a << b[3:0]};
            4'd12:   return {1'b0, ~(a | b)};
            default: return 17'h1A5A5;
        endcase
    endfunction

    assign alu_result = alu_fn(alu_src1, alu_src2, alu_ctrl);
    assign alu_zero   = is_legal(alu_ctrl) ? (alu_result[WIDTH-1:0] == '0) : 1'b1;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int pick(input logic v0, input logic v1, input logic ptr);
        if (v0 && v1) begin
`ifdef ALU_ARB_ROUND_ROBIN_EN
            return ptr ? 0 : 1;
`else
            return 0;
`endif
        end
        if (v0) return 0;
        if (v1) return 1;
        return -1;
    endfunction

    // Model: m_age counts cycles since acceptance (0 = no op in flight).
    int               m_age, m_owner;
    logic             m_ptr;
    logic [WIDTH-1:0] m_src1, m_src2;
    logic [3:0]       m_op;
    logic [WIDTH:0]   m_res;
    logic             m_zero, m_err;

    task automatic model_reset();
        m_age = 0; m_owner = 0; m_ptr = 1'b1;
        m_src1 = '0; m_src2 = '0; m_op = '0;
        m_res = '0; m_zero = 1'b0; m_err = 1'b0;
    endtask

    initial model_reset();

    always @(negedge clk) begin
        int w;
        if (rst) model_reset();
        w = pick(req0_valid, req1_valid, m_ptr);
        chk("req0_ready", 32'(req0_ready), 32'(!rst && m_age == 0 && w == 0));
        chk("req1_ready", 32'(req1_ready), 32'(!rst && m_age == 0 && w == 1));
        chk("rsp0_valid", 32'(rsp0_valid), 32'(m_age >= 2 && m_owner == 0));
        chk("rsp1_valid", 32'(rsp1_valid), 32'(m_age >= 2 && m_owner == 1));
        chk("rsp_result", 32'(rsp_result), 32'(m_res));
        chk("rsp_zero",   32'(rsp_zero),   32'(m_zero));
        chk("rsp_err",    32'(rsp_err),    32'(m_err));
        chk("alu_src1",   32'(alu_src1),   32'(m_src1));
        chk("alu_src2",   32'(alu_src2),   32'(m_src2));
        chk("alu_ctrl",   32'(alu_ctrl),   32'(m_op));
        if (!rst) begin
            if (m_age == 0) begin
                if (w >= 0) begin
                    m_age = 1; m_owner = w; m_ptr = (w == 1);
                    m_src1 = (w == 1) ? req1_src1 : req0_src1;
                    m_src2 = (w == 1) ? req1_src2 : req0_src2;
                    m_op   = (w == 1) ? req1_op   : req0_op;
                end
            end else if (m_age == 1) begin
                m_age  = 2;
                m_err  = !is_legal(m_op);
                m_res  = m_err ? '0 : alu_fn(m_src1, m_src2, m_op);
                m_zero = !m_err && (m_res[WIDTH-1:0] == '0);
            end else if (m_owner == 0 ? rsp0_ready : rsp1_ready) begin
                m_age = 0;
            end
        end
    end

    // Requester-side acceptance observer (drives the bench requesters, logs grants).
    logic acc0 = 1'b0, acc1 = 1'b0;
    int   grants[$];

    always @(negedge clk) begin
        acc0 = req0_valid && req0_ready;
        acc1 = req1_valid && req1_ready;
        if (acc0) grants.push_back(0);
        if (acc1) grants.push_back(1);
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [3:0] rand_op();
        logic [3:0] ops [7] = '{4'd0, 4'd1, 4'd2, 4'd6, 4'd7, 4'd8, 4'd12};
        if ($urandom_range(0, 4) == 0) return 4'($urandom);
        return ops[$urandom_range(0, 6)];
    endfunction

    initial begin
        rst = 1'b1;
        req0_valid = 0; req1_valid = 0; rsp0_ready = 0; rsp1_ready = 0;
        req0_src1 = '0; req0_src2 = '0; req1_src1 = '0; req1_src2 = '0;
        req0_op = '0; req1_op = '0;
        #1;
        chk("reset_rsp0_valid", 32'(rsp0_valid), 32'd0);
        chk("reset_rsp_result", 32'(rsp_result), 32'd0);
        chk("reset_alu_src1",   32'(alu_src1),   32'd0);
        step(); step();
        rst = 1'b0;

        // Single ADD from requester 0
        req0_valid = 1; req0_src1 = 16'h0003; req0_src2 = 16'h0004; req0_op = 4'b0010;
        rsp0_ready = 1;
        #1 chk("add_req0_ready", 32'(req0_ready), 32'd1);
        step(); req0_valid = 0;
        chk("add_alu_src1", 32'(alu_src1), 32'h3);
        chk("add_alu_ctrl", 32'(alu_ctrl), 32'h2);
        chk("add_exec_rsp0_valid", 32'(rsp0_valid), 32'd0);
        step();
        chk("add_rsp0_valid", 32'(rsp0_valid), 32'd1);
        chk("add_result",     32'(rsp_result), 32'h00007);
        chk("add_err",        32'(rsp_err),    32'd0);
        step();
        chk("add_done_rsp0_valid", 32'(rsp0_valid), 32'd0);

        // SUB giving zero from requester 1
        req1_valid = 1; req1_src1 = 16'h1234; req1_src2 = 16'h1234; req1_op = 4'b0110;
        rsp1_ready = 1;
        #1 chk("sub_req1_ready", 32'(req1_ready), 32'd1);
        step(); req1_valid = 0;
        step();
        chk("sub_rsp1_valid", 32'(rsp1_valid), 32'd1);
        chk("sub_rsp0_valid", 32'(rsp0_valid), 32'd0);
        chk("sub_zero",       32'(rsp_zero),   32'd1);
        chk("sub_result",     32'(rsp_result), 32'd0);
        step();

        // Illegal op 0011
        req0_valid = 1; req0_src1 = 16'h00FF; req0_src2 = 16'h0001; req0_op = 4'b0011;
        step(); req0_valid = 0;
        step();
        chk("ill_rsp0_valid", 32'(rsp0_valid), 32'd1);
        chk("ill_err",        32'(rsp_err),    32'd1);
        chk("ill_result",     32'(rsp_result), 32'd0);
        chk("ill_zero",       32'(rsp_zero),   32'd0);
        step();
        chk("ill_done_rsp0_valid", 32'(rsp0_valid), 32'd0);

        // Backpressure on requester 0 while requester 1 waits
        req0_valid = 1; req0_src1 = 16'h0100; req0_src2 = 16'h0023; req0_op = 4'b0010;
        rsp0_ready = 0;
        step(); req0_valid = 0;
        req1_valid = 1; req1_src1 = 16'h0005; req1_src2 = 16'h0006; req1_op = 4'b0010;
        #1 chk("bp_exec_req1_ready", 32'(req1_ready), 32'd0);
        step();
        chk("bp_rsp0_valid", 32'(rsp0_valid), 32'd1);
        chk("bp_result",     32'(rsp_result), 32'h00123);
        for (int i = 0; i < 5; i++) begin
            step();
            chk("bp_hold_rsp0_valid", 32'(rsp0_valid), 32'd1);
            chk("bp_hold_result",     32'(rsp_result), 32'h00123);
            chk("bp_hold_req1_ready", 32'(req1_ready), 32'd0);
        end
        rsp0_ready = 1;
        #1 chk("bp_release_req1_ready", 32'(req1_ready), 32'd0);
        step();
        chk("bp_consumed_rsp0_valid", 32'(rsp0_valid), 32'd0);
        chk("bp_req1_granted",        32'(req1_ready), 32'd1);
        step(); req1_valid = 0;
        step();
        chk("bp_rsp1_valid",  32'(rsp1_valid), 32'd1);
        chk("bp_rsp1_result", 32'(rsp_result), 32'h0000B);
        step(); step();

        // Reset while in EXEC; pending req0 must be re-granted first
        req0_valid = 1; req0_src1 = 16'h00AA; req0_src2 = 16'h0055; req0_op = 4'b0010;
        step();
        chk("rst_pre_alu_src1", 32'(alu_src1), 32'h00AA);
        rst = 1'b1;
        #1;
        chk("rst_alu_src1",   32'(alu_src1),   32'd0);
        chk("rst_alu_ctrl",   32'(alu_ctrl),   32'd0);
        chk("rst_rsp_result", 32'(rsp_result), 32'd0);
        chk("rst_req0_ready", 32'(req0_ready), 32'd0);
        chk("rst_rsp0_valid", 32'(rsp0_valid), 32'd0);
        step(); step();
        rst = 1'b0;
        #1 chk("rst_regrant_req0", 32'(req0_ready), 32'd1);

        // Contention: both requesters continuously valid
        grants.delete();
        req1_valid = 1; req1_src1 = 16'h0010; req1_src2 = 16'h0020; req1_op = 4'b0010;
        rsp0_ready = 1; rsp1_ready = 1;
        for (int i = 0; i < 40 && grants.size() < 4; i++) step();
        chk("cont_grant_count", 32'(grants.size() >= 4), 32'd1);
        if (grants.size() >= 4) begin
`ifdef ALU_ARB_ROUND_ROBIN_EN
            chk("cont_grant0", 32'(grants[0]), 32'd0);
            chk("cont_grant1", 32'(grants[1]), 32'd1);
            chk("cont_grant2", 32'(grants[2]), 32'd0);
            chk("cont_grant3", 32'(grants[3]), 32'd1);
`else
            chk("cont_grant0", 32'(grants[0]), 32'd0);
            chk("cont_grant1", 32'(grants[1]), 32'd0);
            chk("cont_grant2", 32'(grants[2]), 32'd0);
            chk("cont_grant3", 32'(grants[3]), 32'd0);
`endif
        end
        req0_valid = 0; req1_valid = 0;
        repeat (4) step();

        // Randomized traffic checked cycle by cycle against the model
        for (int c = 0; c < 3000; c++) begin
            if (!req0_valid || acc0) begin
                req0_valid = ($urandom_range(0, 3) != 0);
                req0_src1 = 16'($urandom); req0_src2 = 16'($urandom); req0_op = rand_op();
            end
            if (!req1_valid || acc1) begin
                req1_valid = ($urandom_range(0, 3) != 0);
                req1_src1 = 16'($urandom); req1_src2 = 16'($urandom); req1_op = rand_op();
            end
            rsp0_ready = ($urandom_range(0, 3) != 0);
            rsp1_ready = ($urandom_range(0, 3) != 0);
            step();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/alu_arbiter.md
# alu_arbiter

Shares the single combinational `ALU` datapath between two requesters, such as the instruction-execute path and a coprocessor or address-generation unit. Each requester issues an operation over a valid/ready handshake. The arbiter grants one requester, registers the operands and control code into the ALU, captures the result one cycle later, and holds it on a per-requester response channel until that requester accepts it. Only one operation is in flight at a time.

## Interface
Parameters:
- `WIDTH`, default `INTERNAL_BITS` (16): operand width.
- `CTRL_W`, default `ALUCONTROL_BITS` (4): ALU control-code width.

Ports:
- `clk` input 1: single clock, rising edge.
- `rst` input 1: asynchronous, active-high reset.
- `req0_valid`, `req1_valid` input 1: request pending.
- `req0_ready`, `req1_ready` output 1: request accepted this cycle.
- `req0_src1`, `req0_src2`, `req1_src1`, `req1_src2` input WIDTH: operands.
- `req0_op`, `req1_op` input CTRL_W: ALU control code.
- `rsp0_valid`, `rsp1_valid` output 1: result available.
- `rsp0_ready`, `rsp1_ready` input 1: requester takes the result.
- `rsp_result` output WIDTH+1: captured ALU result. Bit WIDTH is the overflow bit.
- `rsp_zero` output 1: captured ALU Zero.
- `rsp_err` output 1: the op was not a legal code.
- `alu_src1`, `alu_src2` output WIDTH: registered operands to the ALU.
- `alu_ctrl` output CTRL_W: registered control code to the ALU.
- `alu_result` input WIDTH+1: from ALU `Result`.
- `alu_zero` input 1: from ALU `Zero`.

## Operation
- FSM states: IDLE, EXEC, RESP. Reset state is IDLE.
- IDLE:
  - If any `reqN_valid` is high, arbitrate and assert the winner's `reqN_ready` combinationally.
  - On that edge, latch the winner's src1, src2 and op into the `alu_*` registers, record the owner, and go to EXEC.
  - `reqN_ready` is high only in IDLE, and only for the granted requester.
- EXEC:
  - Latch `alu_result` and `alu_zero` into the response registers.
  - Set `rsp_err` when the latched op is not one of 0000, 0001, 0010, 0110, 0111, 1000, 1100.
  - For an illegal op, force `rsp_result` = 0 and `rsp_zero` = 0.
  - Go to RESP.
- RESP:
  - Assert the owner's `rspN_valid` only. The other `rspN_valid` stays 0.
  - When the owner's `rspN_ready` is high at an edge, deassert valid and go to IDLE.
  - The `rspN_ready` of the non-owner is ignored.
- Requesters must hold valid and payload stable until ready. The arbiter does not check this.
- Arbitration: see Configuration. A single valid requester always wins.
- The `alu_*` registers hold their last value outside EXEC. They are not cleared after use.
- Response registers hold until overwritten in the next EXEC.

## Timing
- Reset: all outputs and registers are 0, state is IDLE, round-robin pointer is 1 (requester 0 wins first).
- Reset asserted mid-operation aborts the in-flight op immediately. No response is produced, and the requester must reissue.
- Latency: request accepted at edge T, `alu_*` valid after T, result captured at T+1, `rspN_valid` high from T+1 until consumed.
- Minimum occupancy is 3 cycles per op when `rspN_ready` is tied high: accept, exec, respond.
- The next grant occurs in the cycle after response consumption.
- The arbiter holds no combinational path from `reqN_*` to `alu_*`. The only combinational path is req_valid → req_ready.
- The ALU must settle within one cycle from registered inputs.

## Configuration
- Macro: `ALU_ARB_ROUND_ROBIN_EN`.
- Defined: round-robin arbitration.
  - A 1-bit pointer records the last granted requester.
  - When both are valid, the other requester wins.
  - The pointer updates on each grant.
- Undefined: fixed priority. Requester 0 always wins when both are valid, and the pointer is not implemented.

## Test plan
- Single ADD: req0 src1=0x0003, src2=0x0004, op=0010 with `rsp0_ready`=1. Required: `req0_ready` at T, `rsp0_valid` at T+1 to T+2, `rsp_result`=0x00007, `rsp_err`=0.
- SUB zero: req1 src1=0x1234, src2=0x1234, op=0110. Required: `rsp1_valid` only, `rsp_zero`=1, `rsp0_valid` stays 0.
- Contention: both valid continuously, each issuing ADD. With the macro, grants alternate 0,1,0,1. Without it, all grants go to 0 and req1 starves.
- Backpressure: `rsp0_ready`=0 for 5 cycles. Required: `rsp0_valid` and `rsp_result` are held, `req1_ready` stays 0, and req1 is granted in the cycle after `rsp0_ready` rises.
- Illegal op 0011. Required: `rsp_err`=1, `rsp_result`=0, `rsp_zero`=0, normal handshake.
- Reset in EXEC. Required: all outputs 0 asynchronously, no response. After release, the pending req0 is re-granted first.
